// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input sync, mid-bit sampling FSM, small receive FIFO
// read through a valid/ready handshake, one-cycle frame error pulse, sticky overflow.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overflow,
  input  logic       clr_ovf
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]  CNT_MID  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizer (reset to the idle-high line level)
  // ---------------------------------------------------------------------------
  logic rx_meta_q, rx_s_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             frame_err_q, frame_err_d;
  logic             push;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          // A start bit that is already high again at mid-bit was a glitch.
          state_d   = rx_s_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s_q;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_HIGH: begin
        // Holding here on a break line keeps it from re-triggering errors.
        cnt_d = '0;
        if (rx_s_q) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------------------
  logic [FIFO_DEPTH-1:0][7:0] mem_q, mem_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0]          count_q, count_d;
  logic [7:0]                 rx_data_q, rx_data_d;
  logic                       overflow_q, overflow_d;
  logic                       do_push, do_pop, full, ovf_set;

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rx_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rx_data_q  <= rx_data_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  always_comb begin
    full    = (count_q == FIFO_FULL);
    do_pop  = (count_q != '0) && rx_ready;
    do_push = push && (!full || do_pop);
    ovf_set = push && full && !do_pop;

    mem_d = mem_q;
    if (do_push) mem_d[wr_ptr_q] = shift_q;

    wr_ptr_d = wr_ptr_q + (do_push ? PTR_W'(1) : PTR_W'(0));
    rd_ptr_d = rd_ptr_q + (do_pop  ? PTR_W'(1) : PTR_W'(0));

    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + FCNT_W'(1);
      2'b01:   count_d = count_q - FCNT_W'(1);
      default: count_d = count_q;
    endcase

    // Registered head: the byte landing this cycle bypasses storage when it
    // becomes the new head, and the last value is held once empty.
    rx_data_d = rx_data_q;
    if (count_d != '0) begin
      if (do_push && (wr_ptr_q == rd_ptr_d)) rx_data_d = shift_q;
      else                                   rx_data_d = mem_q[rd_ptr_d];
    end

    overflow_d = overflow_q;
    if (ovf_set)      overflow_d = 1'b1;
    else if (clr_ovf) overflow_d = 1'b0;
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = (count_q != '0);
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

endmodule
